arbiter: RTL and testbench

ARBITER -- requirements
Module: arbiter

---
 rtl/arbiter.sv | 74 +++++++
 tb/tb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/arbiter.sv
// arbiter: four-input round-robin AXI-Stream arbiter with packet-granular grants.
// A grant is taken in IDLE and held in BUSY until the granted packet's last beat handshakes.
module arbiter #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [3:0][DATA_W-1:0] i_in_t_data,
    input  logic [3:0][ID_W-1:0]   i_in_t_id,
    input  logic [3:0]             i_in_t_last,
    input  logic [3:0]             i_in_t_valid,
    output logic [3:0]             o_in_t_ready,
    output logic [DATA_W-1:0]      o_out_t_data,
    output logic [ID_W-1:0]        o_out_t_id,
    output logic                   o_out_t_last,
    output logic                   o_out_t_valid,
    input  logic                   i_out_t_ready,
    output logic [1:0]             idx_channel
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, r_grant, w_pick, w_ptr_nxt, w_grant_nxt;
    logic       w_busy, w_pkt_end;

    // Scan from the farthest offset down so the channel nearest ptr wins.
    always_comb begin
        w_pick = r_ptr;
        for (int k = 3; k >= 0; k--)
            if (i_in_t_valid[r_ptr + 2'(k)]) w_pick = r_ptr + 2'(k);
    end

    assign w_busy        = r_state == BUSY;
    assign o_out_t_data  = i_in_t_data[r_grant];
    assign o_out_t_id    = i_in_t_id[r_grant];
    assign o_out_t_last  = i_in_t_last[r_grant];
    assign o_out_t_valid = w_busy & i_in_t_valid[r_grant];
    assign w_pkt_end     = o_out_t_valid & i_out_t_ready & o_out_t_last;
    assign idx_channel   = r_grant;

    always_comb begin
        o_in_t_ready          = '0;
        o_in_t_ready[r_grant] = w_busy & i_out_t_ready;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: if (|i_in_t_valid) begin
                w_state_nxt = BUSY;
                w_grant_nxt = w_pick;
            end
            BUSY: if (w_pkt_end) begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = r_grant + 2'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_grant <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
        end
    end
endmodule

// File: tb/tb_arbiter.sv
// tb_arbiter: directed checks of grant order, stalls, valid gaps and reset for arbiter.
// Beat data encodes {channel, packet, beat} so every delivered beat is checkable.
module tb_arbiter;
    localparam int DW = 32;
    localparam int IW = 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [3:0][DW-1:0]  in_data;
    logic [3:0][IW-1:0]  in_id;
    logic [3:0]          in_last, in_valid, in_ready;
    logic [DW-1:0]       out_data;
    logic [IW-1:0]       out_id;
    logic                out_last, out_valid;
    logic                out_ready = 1'b1;
    logic [1:0]          idx;

    int checks = 0;
    int errors = 0;

    int  npkt[4], pkt[4], beat[4];
    int  len[4][8];
    bit  en[4];
    bit  mon = 0;
    bit  rnd = 0;
    logic [DW-1:0] exp_d[$];
    logic [IW-1:0] exp_i[$];
    logic [1:0]    exp_c[$];

    always #5 clk = ~clk;

    arbiter #(.DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_in_t_data(in_data), .i_in_t_id(in_id), .i_in_t_last(in_last),
        .i_in_t_valid(in_valid), .o_in_t_ready(in_ready),
        .o_out_t_data(out_data), .o_out_t_id(out_id), .o_out_t_last(out_last),
        .o_out_t_valid(out_valid), .i_out_t_ready(out_ready),
        .idx_channel(idx)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_word(input int c, input int p, input int b);
        return {8'(c), 8'(p), 16'(b)};
    endfunction

    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            in_valid[c] = en[c] && pkt[c] < npkt[c];
            in_data[c]  = beat_word(c, pkt[c], beat[c]);
            in_id[c]    = IW'(c * 16 + pkt[c]);
            in_last[c]  = pkt[c] < npkt[c] && beat[c] == len[c][pkt[c]] - 1;
        end
        #1;
    endtask

    task automatic step();
        logic [3:0] hs;
        @(negedge clk);
        hs = in_valid & in_ready;
        if (mon && out_valid && out_ready) begin
            if (exp_d.size() == 0) check("extra_beat", out_data, 0);
            else begin
                check("beat_data", out_data, exp_d.pop_front());
                check("beat_id", out_id, exp_i.pop_front());
                check("beat_idx", idx, exp_c.pop_front());
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++)
            if (hs[c]) begin
                if (beat[c] == len[c][pkt[c]] - 1) begin
                    beat[c] = 0;
                    pkt[c]++;
                end else beat[c]++;
            end
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic rst();
        reset_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            pkt[c] = 0; beat[c] = 0; npkt[c] = 0; en[c] = 0;
        end
        drive();
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic burst(input bit random_ready, input string tag);
        rst();
        rnd = random_ready;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            en[c] = 1;
            npkt[c] = 5;
            for (int p = 0; p < 8; p++) len[c][p] = ((c * 7 + p * 5) % 16) + 1;
        end
        for (int p = 0; p < 5; p++)
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < len[c][p]; b++) begin
                    exp_d.push_back(beat_word(c, p, b));
                    exp_i.push_back(IW'(c * 16 + p));
                    exp_c.push_back(2'(c));
                end
        drive();
        mon = 1;
        for (int n = 0; n < 3000 && exp_d.size() > 0; n++) step();
        mon = 0;
        rnd = 0;
        check({tag, "_beats_left"}, exp_d.size(), 0);
        exp_d.delete(); exp_i.delete(); exp_c.delete();
    endtask

    initial begin
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < 8; p++) len[c][p] = 1;
        // Reset held with every channel requesting: nothing may be granted.
        reset_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            en[c] = 1; npkt[c] = 1; pkt[c] = 0; beat[c] = 0;
        end
        drive();
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 4'b0000);
        check("rst_idx", idx, 0);

        burst(0, "burst");
        burst(1, "burst_rnd");

        // Only channel 2 requests after reset, single-beat packet.
        rst();
        out_ready = 1'b1;
        en[2] = 1; npkt[2] = 1; len[2][0] = 1;
        drive();
        check("idle_out_valid", out_valid, 0);
        step();
        check("ch2_idx", idx, 2);
        check("ch2_valid", out_valid, 1);
        check("ch2_ready", in_ready, 4'b0100);
        check("ch2_last", out_last, 1);
        check("ch2_data", out_data, beat_word(2, 0, 0));
        step();
        check("ch2_end_valid", out_valid, 0);
        check("ch2_end_ready", in_ready, 4'b0000);
        check("ch2_idx_hold", idx, 2);
        for (int c = 0; c < 4; c++) begin
            en[c] = 1; npkt[c] = (c == 2) ? 2 : 1; len[c][0] = 2; len[c][1] = 2;
        end
        drive();
        step();
        check("rr_from3_idx", idx, 3);
        check("rr_from3_ready", in_ready, 4'b1000);

        // Stall with out_ready low, then a valid gap mid-packet.
        out_ready = 1'b0;
        drive();
        check("stall_ready", in_ready, 4'b0000);
        step();
        check("stall_data", out_data, beat_word(3, 0, 0));
        check("stall_idx", idx, 3);
        en[3] = 0;
        drive();
        check("gap_valid", out_valid, 0);
        step();
        check("gap_idx", idx, 3);
        check("gap_valid2", out_valid, 0);
        en[3] = 1;
        out_ready = 1'b1;
        drive();
        check("resume_data", out_data, beat_word(3, 0, 0));
        step();
        check("beat1_data", out_data, beat_word(3, 0, 1));
        check("beat1_last", out_last, 1);
        step();
        check("pkt3_end_valid", out_valid, 0);
        step();
        check("wrap_idx", idx, 0);
        check("wrap_data", out_data, beat_word(0, 0, 0));

        // Reset in the middle of a channel 1 packet.
        rst();
        out_ready = 1'b1;
        en[1] = 1; npkt[1] = 1; len[1][0] = 4;
        drive();
        step();
        check("mid_idx", idx, 1);
        step();
        check("mid_beat1", out_data, beat_word(1, 0, 1));
        reset_n = 1'b0;
        en[0] = 1; npkt[0] = 1; len[0][0] = 2;
        drive();
        step();
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 4'b0000);
        check("midrst_idx", idx, 0);
        reset_n = 1'b1;
        step();
        check("after_rst_idx", idx, 0);
        check("after_rst_valid", out_valid, 1);
        check("after_rst_data", out_data, beat_word(0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
